// File: rtl/pr_region_sequencer.sv
// pr_region_sequencer
//
// Takes one partial-reconfiguration region offline, hands it to the
// configuration engine for a bitstream swap, and brings it back online.
// The sequence is:
//   1. Evict the core.
//   2. Drain resident descriptors.
//   3. Decouple and reset the region.
//   4. Start the configuration engine.
//   5. Wait for the load to finish.
//   6. Hold the core in reset briefly, then release.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   pr_req         level request to reconfigure, sampled only when idle
//   pr_done        one-cycle pulse: bitstream loaded (honoured only in LOAD)
//   pr_start       one-cycle pulse: configuration engine may begin loading
//   pr_busy        high whenever a sequence is in progress
//   pr_error       sticky: EVICT or DRAIN timed out; cleared by rst or next accepted pr_req
//   evict_int      eviction interrupt to the core
//   evict_int_ack  eviction acknowledge from the core (level)
//   in_desc_fire   descriptor accepted by the core
//   out_desc_fire  descriptor returned by the core
//   desc_block     scheduler must stop issuing descriptors to this region
//   decouple       isolates the region handshake signals
//   core_rst       reset to the region's core
//   outstanding    number of descriptors currently resident in the core
//
// Every output is a flop. Its next value is decoded from the next state,
// so each output changes on the same edge as the state it belongs to.
module pr_region_sequencer #(
  parameter int SLOT_COUNT = 8,
  parameter int SLOT_WIDTH = $clog2(SLOT_COUNT + 1),
  parameter int TIMEOUT    = 65535,
  parameter int RST_HOLD   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pr_req,
  input  logic                  pr_done,
  output logic                  pr_start,
  output logic                  pr_busy,
  output logic                  pr_error,
  output logic                  evict_int,
  input  logic                  evict_int_ack,
  input  logic                  in_desc_fire,
  input  logic                  out_desc_fire,
  output logic                  desc_block,
  output logic                  decouple,
  output logic                  core_rst,
  output logic [SLOT_WIDTH-1:0] outstanding
);

  // One shared timer serves the EVICT/DRAIN timeouts and the two reset
  // holds, so it must be wide enough for the larger of the two limits.
  localparam int TIMER_MAX = (TIMEOUT > RST_HOLD) ? TIMEOUT : RST_HOLD;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0]    TIMEOUT_T = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0]    HOLD_LAST = TIMER_W'(RST_HOLD - 1);
  localparam logic [SLOT_WIDTH-1:0] SLOT_MAX  = SLOT_WIDTH'(SLOT_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVICT,
    S_DRAIN,
    S_DECOUPLE,
    S_LOAD,
    S_RESET
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [TIMER_W-1:0]      timer;
  logic [TIMER_W-1:0]      timer_nxt;
  logic [SLOT_WIDTH-1:0]   outstanding_nxt;
  logic                    pr_error_nxt;
  logic                    pr_start_nxt;
  logic                    pr_busy_nxt;
  logic                    evict_int_nxt;
  logic                    desc_block_nxt;
  logic                    decouple_nxt;
  logic                    core_rst_nxt;
  logic                    timed_out;

  // Saturating up/down step.
  // A simultaneous accept and return cancel out and leave the count unchanged.
  function automatic logic [SLOT_WIDTH-1:0] count_step(
    input logic [SLOT_WIDTH-1:0] cur,
    input logic                  inc,
    input logic                  dec
  );
    logic [SLOT_WIDTH-1:0] res;
    res = cur;
    if (inc && !dec && (cur != SLOT_MAX)) begin
      res = cur + 1'b1;
    end else if (dec && !inc && (cur != '0)) begin
      res = cur - 1'b1;
    end
    return res;
  endfunction

  assign timed_out = (timer == TIMEOUT_T);

  always_comb begin
    state_nxt       = state;
    pr_error_nxt    = pr_error;
    timer_nxt       = '0;
    outstanding_nxt = outstanding;

    unique case (state)
      S_IDLE: begin
        if (pr_req) begin
          state_nxt    = S_EVICT;
          pr_error_nxt = 1'b0;
        end
      end
      S_EVICT: begin
        // An acknowledge on the timeout cycle still counts as a clean eviction.
        if (evict_int_ack) begin
          state_nxt = S_DRAIN;
        end else if (timed_out) begin
          state_nxt    = S_DECOUPLE;
          pr_error_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        // An empty core on the timeout cycle is a clean drain, not an error.
        if (outstanding == '0) begin
          state_nxt = S_DECOUPLE;
        end else if (timed_out) begin
          state_nxt    = S_DECOUPLE;
          pr_error_nxt = 1'b1;
        end
      end
      S_DECOUPLE: begin
        if (timer == HOLD_LAST) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pr_done) begin
          state_nxt = S_RESET;
        end
      end
      S_RESET: begin
        if (timer == HOLD_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // The timer restarts from 0 on every state change.
    // It only runs in the states that measure time; elsewhere it rests at 0.
    if ((state_nxt == state) &&
        (state inside {S_EVICT, S_DRAIN, S_DECOUPLE, S_RESET})) begin
      timer_nxt = timer + 1'b1;
    end

    // The counter tracks fires only until the region is decoupled.
    // From DECOUPLE onward whatever was resident is lost with the core,
    // so the counter is held at 0.
    if (state_nxt inside {S_DECOUPLE, S_LOAD, S_RESET}) begin
      outstanding_nxt = '0;
    end else if (state inside {S_IDLE, S_EVICT, S_DRAIN}) begin
      outstanding_nxt = count_step(outstanding, in_desc_fire, out_desc_fire);
    end

    pr_busy_nxt    = (state_nxt != S_IDLE);
    desc_block_nxt = (state_nxt != S_IDLE);
    evict_int_nxt  = (state_nxt == S_EVICT);
    decouple_nxt   = (state_nxt inside {S_DECOUPLE, S_LOAD});
    core_rst_nxt   = (state_nxt inside {S_DECOUPLE, S_LOAD, S_RESET});
    // Raised in the last DECOUPLE cycle.
    // When RST_HOLD is 1, that is also the first DECOUPLE cycle.
    pr_start_nxt   = (state_nxt == S_DECOUPLE) && (timer_nxt == HOLD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      outstanding <= '0;
      pr_error    <= 1'b0;
      pr_start    <= 1'b0;
      pr_busy     <= 1'b0;
      evict_int   <= 1'b0;
      desc_block  <= 1'b0;
      decouple    <= 1'b0;
      core_rst    <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      outstanding <= outstanding_nxt;
      pr_error    <= pr_error_nxt;
      pr_start    <= pr_start_nxt;
      pr_busy     <= pr_busy_nxt;
      evict_int   <= evict_int_nxt;
      desc_block  <= desc_block_nxt;
      decouple    <= decouple_nxt;
      core_rst    <= core_rst_nxt;
    end
  end

endmodule

// File: tb/tb_pr_region_sequencer.sv
// Testbench for pr_region_sequencer.
// A phase-level reference model predicts every output on every cycle.
// Directed scenarios additionally pin key cycle counts to literal values.
module tb_pr_region_sequencer;

  localparam int SLOT_COUNT = 8;
  localparam int TIMEOUT    = 100;
  localparam int RST_HOLD   = 16;
  localparam int SW         = $clog2(SLOT_COUNT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          pr_req;
  logic          pr_done;
  logic          pr_start;
  logic          pr_busy;
  logic          pr_error;
  logic          evict_int;
  logic          evict_int_ack;
  logic          in_desc_fire;
  logic          out_desc_fire;
  logic          desc_block;
  logic          decouple;
  logic          core_rst;
  logic [SW-1:0] outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pr_region_sequencer #(
    .SLOT_COUNT (SLOT_COUNT),
    .TIMEOUT    (TIMEOUT),
    .RST_HOLD   (RST_HOLD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pr_req        (pr_req),
    .pr_done       (pr_done),
    .pr_start      (pr_start),
    .pr_busy       (pr_busy),
    .pr_error      (pr_error),
    .evict_int     (evict_int),
    .evict_int_ack (evict_int_ack),
    .in_desc_fire  (in_desc_fire),
    .out_desc_fire (out_desc_fire),
    .desc_block    (desc_block),
    .decouple      (decouple),
    .core_rst      (core_rst),
    .outstanding   (outstanding)
  );

  // ---------------------------------------------------------------------
  // Reference model.
  // It tracks which phase of the sequence the region is in, how many
  // cycles it has spent there, the resident descriptor count and the
  // error flag. Expected outputs follow directly from that phase.
  // ---------------------------------------------------------------------
  localparam int P_IDLE = 0, P_EVICT = 1, P_DRAIN = 2, P_DEC = 3, P_LOAD = 4, P_RST = 5;

  int m_phase = P_IDLE;
  int m_age   = 0;
  int m_cnt   = 0;
  int m_np;
  bit m_err   = 1'b0;
  bit m_live  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_IDLE;
      m_age   = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      m_np = m_phase;
      case (m_phase)
        P_IDLE:  if (pr_req) begin m_np = P_EVICT; m_err = 1'b0; end
        P_EVICT: if (evict_int_ack) m_np = P_DRAIN;
                 else if (m_age == TIMEOUT) begin m_np = P_DEC; m_err = 1'b1; end
        P_DRAIN: if (m_cnt == 0) m_np = P_DEC;
                 else if (m_age == TIMEOUT) begin m_np = P_DEC; m_err = 1'b1; end
        P_DEC:   if (m_age == RST_HOLD - 1) m_np = P_LOAD;
        P_LOAD:  if (pr_done) m_np = P_RST;
        P_RST:   if (m_age == RST_HOLD - 1) m_np = P_IDLE;
        default: m_np = P_IDLE;
      endcase
      if (m_phase <= P_DRAIN) begin
        if (m_np >= P_DEC) begin
          m_cnt = 0;
        end else begin
          m_cnt = m_cnt + int'(in_desc_fire) - int'(out_desc_fire);
          if (m_cnt > SLOT_COUNT) m_cnt = SLOT_COUNT;
          if (m_cnt < 0) m_cnt = 0;
        end
      end
      m_age   = (m_np == m_phase) ? m_age + 1 : 0;
      m_phase = m_np;
    end
  end

  logic [6+SW:0] act_vec;
  logic [6+SW:0] exp_vec;

  assign act_vec = {pr_start, pr_busy, pr_error, evict_int, desc_block, decouple, core_rst, outstanding};

  always @(negedge clk) begin
    if (m_live) begin
      exp_vec = {(m_phase == P_DEC) && (m_age == RST_HOLD - 1),
                 m_phase != P_IDLE,
                 m_err,
                 m_phase == P_EVICT,
                 m_phase != P_IDLE,
                 (m_phase == P_DEC) || (m_phase == P_LOAD),
                 (m_phase >= P_DEC),
                 SW'(m_cnt)};
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t got %b expected %b (start,busy,err,evict,block,dec,crst,outstanding)",
                 $time, act_vec, exp_vec);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Returns at the pr_start cycle.
  // Reports how many decouple cycles came up to and including it.
  task automatic wait_start(output int dec_cycles);
    bit found;
    found      = 1'b0;
    dec_cycles = 0;
    for (int i = 0; i < 500; i++) begin
      if (decouple) dec_cycles++;
      if (pr_start) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) check("pr_start_seen", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (pr_busy && n < 500) begin
      tick();
      n++;
    end
    if (pr_busy) check("return_to_idle", 0, 1);
  endtask

  task automatic finish_seq();
    int dc;
    wait_start(dc);
    repeat (5) tick();
    pr_done = 1'b1;
    tick();
    pr_done = 1'b0;
    wait_idle();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int dc;
    int n;
    rst = 1'b1; pr_req = 1'b0; pr_done = 1'b0; evict_int_ack = 1'b0;
    in_desc_fire = 1'b0; out_desc_fire = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_state", int'(act_vec), 0);

    // Nominal sequence with an empty core.
    pr_req = 1'b1; tick(); pr_req = 1'b0;
    check("evict_rise", int'({evict_int, desc_block, pr_busy}), 7);
    repeat (3) tick();
    check("evict_4th_cycle", int'(evict_int), 1);
    evict_int_ack = 1'b1; tick(); evict_int_ack = 1'b0;
    check("evict_fall", int'(evict_int), 0);
    wait_start(dc);
    check("decouple_before_start", dc, 16);
    tick();
    check("pr_start_width", int'(pr_start), 0);
    repeat (49) tick();
    pr_done = 1'b1; tick(); pr_done = 1'b0;
    check("decouple_after_done", int'({decouple, core_rst}), 1);
    n = 0;
    while (core_rst && n < 100) begin tick(); n++; end
    check("core_rst_hold", n, 16);
    check("nominal_idle", int'({pr_busy, desc_block, pr_error}), 0);

    // Drain with three resident descriptors, including a simultaneous fire.
    in_desc_fire = 1'b1; repeat (3) tick(); in_desc_fire = 1'b0;
    check("preload_count", int'(outstanding), 3);
    pr_req = 1'b1; tick(); pr_req = 1'b0;
    evict_int_ack = 1'b1; tick(); evict_int_ack = 1'b0;
    in_desc_fire = 1'b1; out_desc_fire = 1'b1; tick();
    in_desc_fire = 1'b0; out_desc_fire = 1'b0;
    check("simultaneous_fire", int'(outstanding), 3);
    for (int k = 1; k <= 3; k++) begin
      out_desc_fire = 1'b1; tick(); out_desc_fire = 1'b0;
      check("drain_count", int'(outstanding), 3 - k);
      check("drain_no_decouple", int'(decouple), 0);
      if (k < 3) tick();
    end
    tick();
    check("drain_exit", int'({decouple, core_rst}), 3);
    finish_seq();

    // Eviction timeout: the acknowledge never arrives.
    pr_req = 1'b1; tick(); pr_req = 1'b0;
    n = 0;
    while (evict_int && n < 500) begin tick(); n++; end
    check("evict_timeout_cycles", n, 101);
    check("timeout_flags", int'({pr_error, decouple}), 3);
    finish_seq();
    check("error_sticky", int'(pr_error), 1);
    pr_req = 1'b1; tick(); pr_req = 1'b0;
    check("error_cleared", int'(pr_error), 0);
    evict_int_ack = 1'b1; tick(); evict_int_ack = 1'b0;
    finish_seq();

    // Counter saturation at both ends.
    in_desc_fire = 1'b1; repeat (10) tick(); in_desc_fire = 1'b0;
    check("sat_high", int'(outstanding), 8);
    out_desc_fire = 1'b1; repeat (10) tick(); out_desc_fire = 1'b0;
    check("sat_low", int'(outstanding), 0);

    // Reset in the middle of LOAD.
    pr_req = 1'b1; tick(); pr_req = 1'b0;
    evict_int_ack = 1'b1; tick(); evict_int_ack = 1'b0;
    wait_start(dc);
    repeat (2) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_load", int'(act_vec), 0);
    pr_done = 1'b1; tick(); pr_done = 1'b0;
    repeat (2) tick();
    check("late_done_ignored", int'({pr_busy, core_rst, decouple}), 0);

    // Spurious pr_done while idle, then pr_req held through a whole sequence.
    pr_done = 1'b1; tick(); pr_done = 1'b0;
    check("spurious_done", int'(pr_busy), 0);
    pr_req = 1'b1; tick();
    check("held_req_start", int'(pr_busy), 1);
    evict_int_ack = 1'b1; tick(); evict_int_ack = 1'b0;
    wait_start(dc);
    repeat (3) tick();
    pr_done = 1'b1; tick(); pr_done = 1'b0;
    wait_idle();
    check("idle_gap", int'(pr_busy), 0);
    tick();
    check("second_seq_start", int'({pr_busy, evict_int}), 3);
    pr_req = 1'b0;
    evict_int_ack = 1'b1; tick(); evict_int_ack = 1'b0;
    finish_seq();

    // Randomized traffic, checked cycle by cycle against the model.
    // Some segments starve the acknowledge or the returns so that both
    // EVICT and DRAIN timeouts occur.
    for (int c = 0; c < 5000; c++) begin
      int seg;
      seg           = c / 1000;
      rst           = ($urandom_range(0, 399) == 0);
      pr_req        = ($urandom_range(0, 5) == 0);
      pr_done       = ($urandom_range(0, 11) == 0);
      evict_int_ack = (seg == 1) ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 4) == 0);
      in_desc_fire  = ($urandom_range(0, 1) == 0);
      out_desc_fire = (seg == 2) ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 1) == 0);
      tick();
    end
    rst = 1'b0; pr_req = 1'b0; pr_done = 1'b0; evict_int_ack = 1'b0;
    in_desc_fire = 1'b0; out_desc_fire = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pr_region_sequencer.md
# pr_region_sequencer

Sequencer that takes one RISC-V partial-reconfiguration region offline, has its bitstream swapped, and brings it back online. It sits in the static region between the scheduler-side descriptor links and the register-sliced PR block. It evicts the core, drains outstanding slots, decouples and resets the region, and hands off to the configuration engine. It then releases the region once the new image is loaded.

## Interface
Parameters:
- SLOT_COUNT, 8, maximum descriptors resident in the core.
- SLOT_WIDTH, $clog2(SLOT_COUNT+1), width of the outstanding counter.
- TIMEOUT, 65535, cycle limit for each of EVICT and DRAIN.
- RST_HOLD, 16, cycles reset and decouple are held to flush the region's pipe registers.

Ports:
- clk  in  1  clock. One clock only; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- pr_req  in  1  level request to reconfigure; sampled in IDLE only.
- pr_done  in  1  one-cycle pulse from the configuration engine when the bitstream is loaded.
- pr_start  out  1  one-cycle pulse telling the configuration engine to begin loading.
- pr_busy  out  1  high in every state except IDLE.
- pr_error  out  1  sticky timeout flag; cleared only by rst or by the next accepted pr_req.
- evict_int  out  1  eviction interrupt to the core.
- evict_int_ack  in  1  eviction acknowledge from the core, level.
- in_desc_fire  in  1  descriptor accepted by the core (valid && taken).
- out_desc_fire  in  1  descriptor returned by the core (valid && ready).
- desc_block  out  1  tells the scheduler to stop issuing descriptors to this region.
- decouple  out  1  isolates all region handshake signals.
- core_rst  out  1  reset to the region's core.
- outstanding  out  SLOT_WIDTH  current count of resident descriptors.

## Operation
- Outstanding counter:
  - +1 on in_desc_fire, -1 on out_desc_fire; unchanged when both fire together.
  - Saturates at SLOT_COUNT and at 0.
  - Forced to 0 on entry to DECOUPLE.
- State machine, all outputs registered:
  - IDLE: all control outputs 0. If pr_req=1: go to EVICT, clear pr_error, set desc_block=1 and evict_int=1.
  - EVICT: hold evict_int=1 until evict_int_ack=1, then evict_int=0 and go to DRAIN.
  - DRAIN: go to DECOUPLE when outstanding==0.
  - Timeout in EVICT or DRAIN: a shared timer counts from 0 in each state. When it reaches TIMEOUT, set pr_error=1, drop evict_int, and go to DECOUPLE.
  - DECOUPLE: decouple=1, core_rst=1, timer counts RST_HOLD cycles. On the final cycle, pulse pr_start for exactly 1 cycle and go to LOAD.
  - LOAD: hold decouple=1 and core_rst=1. On pr_done go to RESET.
  - RESET: decouple=0, core_rst=1 for RST_HOLD cycles, then go to IDLE. desc_block, core_rst and pr_busy all fall on IDLE entry.
- pr_done outside LOAD is ignored.
- pr_req outside IDLE is ignored. pr_req still high on return to IDLE starts a new sequence.
- rst at any point: immediate return to IDLE; all outputs 0; outstanding=0; timer=0.

## Timing
- Reset value of every output is 0, including outstanding.
- pr_req high in cycle N: evict_int, desc_block and pr_busy are high in cycle N+1.
- evict_int_ack high in cycle N: evict_int is low in N+1, and the state is DRAIN in N+1.
- DRAIN exits the cycle after outstanding reads 0; decouple and core_rst are high in that next cycle.
- The DECOUPLE-to-pr_start delay is exactly RST_HOLD cycles; pr_start is high during the last DECOUPLE cycle.
- pr_done in cycle N: decouple=0 in N+1. core_rst stays high through N+RST_HOLD and is low in N+RST_HOLD+1.
- The timeout fires on the cycle the timer equals TIMEOUT. With ack never arriving, EVICT lasts exactly TIMEOUT+1 cycles.
- Fire inputs continue to update the counter in all states before DECOUPLE.

## Test plan
- Nominal sequence, outstanding=0:
  - Stimulus: pr_req. Ack 3 cycles later. pr_done 50 cycles after pr_start.
  - Response: evict_int high for 4 cycles; pr_start one pulse after 16 decouple cycles; core_rst low 16 cycles after pr_done; pr_error=0.
- Drain with 3 resident descriptors:
  - Stimulus: outstanding=3 when the ack arrives; out_desc_fire pulses follow. Also drive in_desc_fire and out_desc_fire in the same cycle.
  - Response: DECOUPLE is entered only after the third return; the simultaneous fire leaves the count unchanged.
- Eviction timeout, TIMEOUT=100:
  - Stimulus: the ack never arrives.
  - Response: pr_error=1 after 101 EVICT cycles; decouple asserts; the sequence completes; pr_error clears on the next pr_req.
- Counter saturation:
  - Stimulus: 10 in_desc_fire pulses with SLOT_COUNT=8; then 10 out_desc_fire pulses.
  - Response: outstanding stops at 8, then at 0.
- Reset mid-LOAD:
  - Stimulus: assert rst for 1 cycle during LOAD.
  - Response: all outputs 0 the next cycle; a pr_done arriving later is ignored; the FSM stays in IDLE.
- Spurious pr_done in IDLE and a held pr_req:
  - Stimulus: pr_done pulse while IDLE; pr_req held high through one full sequence.
  - Response: the pr_done has no effect; a second sequence starts the cycle after the FSM returns to IDLE.
